mem_port_arbiter: RTL

Two-requester arbiter that shares the processor's single memory port between instruction fetch (requester 0) and data access (requester 1). It runs a small FSM, grants one requester at a time with round-robin fairness, and drives `mux_sel` onto the external `mux_2x1` instances that steer address, write data and write enable to the memory. It captures the memory response into a holding register. A watchdog ends any access the memory fails to complete.

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: state encoding and the
// round-robin owner selection used when the port is idle.
package mem_port_arbiter_pkg;

    // Same encoding is reused by the processor's multi-cycle control.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY0 = 2'b01,
        BUSY1 = 2'b10
    } arb_state_e;

    // Choose the next owner from the eligible requests. On a tie the
    // requester that did not win last time gets the port.
    function automatic arb_state_e pick_owner(input logic elig0,
                                              input logic elig1,
                                              input logic last_winner);
        arb_state_e owner;
        owner = IDLE;
        if (elig0 && elig1) begin
            owner = last_winner ? BUSY0 : BUSY1;
        end else if (elig0) begin
            owner = BUSY0;
        end else if (elig1) begin
            owner = BUSY1;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port (fetch = 0, data = 1).
// Grants one requester at a time round-robin, drives the external datapath
// mux select, captures the read data and aborts accesses that never finish.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int Bits    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic            req1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            mux_sel,
    output logic            mem_req,
    input  logic            mem_ready,
    input  logic [Bits-1:0] mem_rdata,
    output logic [Bits-1:0] rdata,
    output logic            done0,
    output logic            done1,
    output logic            err
);

    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_winner_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             mux_sel_q;
    logic             mem_req_q;
    logic [Bits-1:0]  rdata_q;
    logic             done0_q;
    logic             done1_q;
    logic             err_q;

    arb_state_e       owner_d;
    logic             timeout_hit;

    // Next owner while idle. No grant is made in the cycle a done pulse is
    // out, so a requester still holding req is never re-granted instantly
    // and the idle cycle overlaps the completion pulse.
    always_comb begin
        owner_d     = pick_owner(req0 & ~(done0_q | done1_q),
                                 req1 & ~(done0_q | done1_q),
                                 last_winner_q);
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // Arbiter FSM with registered grant, strobe, select, data and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_winner_q <= 1'b1;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            mux_sel_q     <= 1'b0;
            mem_req_q     <= 1'b0;
            rdata_q       <= '0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (owner_d != IDLE) begin
                        state_q   <= owner_d;
                        cnt_q     <= '0;
                        gnt0_q    <= (owner_d == BUSY0);
                        gnt1_q    <= (owner_d == BUSY1);
                        mux_sel_q <= (owner_d == BUSY1);
                        mem_req_q <= 1'b1;
                    end
                end
                BUSY0, BUSY1: begin
                    if (mem_ready || timeout_hit) begin
                        // A timed-out access returns zero data with err set.
                        rdata_q       <= mem_ready ? mem_rdata : '0;
                        err_q         <= ~mem_ready;
                        state_q       <= IDLE;
                        gnt0_q        <= 1'b0;
                        gnt1_q        <= 1'b0;
                        mem_req_q     <= 1'b0;
                        last_winner_q <= (state_q == BUSY1);
                        done0_q       <= (state_q == BUSY0);
                        done1_q       <= (state_q == BUSY1);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    gnt0_q    <= 1'b0;
                    gnt1_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign mux_sel = mux_sel_q;
    assign mem_req = mem_req_q;
    assign rdata   = rdata_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign err     = err_q;

endmodule
